// File: rtl/adc_spi_sequencer.sv
// Periodic SPI ADC sampler: mode-0 master, timed ADC reset pulse and
// a show-ahead sample FIFO drained through a valid/ready port.
module adc_spi_sequencer #(
    parameter int CLK_DIV       = 4,
    parameter int FRAME_BITS    = 16,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int FIFO_DEPTH    = 8,
    parameter int RESET_CYCLES  = 16
) (
    input  logic                                 clk_clk,
    input  logic                                 reset_reset,
    input  logic                                 enable,
    input  logic                                 adc_reset_req,
    input  logic [FRAME_BITS-1:0]                cmd_word,
    output logic                                 spi_sclk,
    output logic                                 spi_mosi,
    output logic                                 spi_ss_n,
    input  logic                                 spi_miso,
    output logic                                 adc_rst,
    output logic [FRAME_BITS-1:0]                sample_data,
    output logic                                 sample_valid,
    input  logic                                 sample_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
    output logic                                 overflow,
    output logic                                 trig_miss,
    input  logic                                 flags_clr,
    output logic                                 busy
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(FRAME_BITS);
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_PUSH,
        S_RST
    } state_t;

    state_t                state_q;
    logic [DW-1:0]         div_q;
    logic [BW-1:0]         bit_q;
    logic [RW-1:0]         rc_q;
    logic [PW-1:0]         per_q, per_d;
    logic [FRAME_BITS-1:0] tx_q, rx_q;
    logic                  req_q;
    logic                  ss_n_q, sclk_q, mosi_q, adc_rst_q;

    logic [FRAME_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_q, rd_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d, miss_q, miss_d;

    logic trig, rst_edge, div_end, last_bit;
    logic push, pop, full, do_push, ovf_set, miss_set;

    assign trig     = enable && (per_q == PW'(SAMPLE_PERIOD - 1));
    assign rst_edge = adc_reset_req && !req_q;
    assign div_end  = (div_q == DW'(CLK_DIV - 1));
    assign last_bit = (bit_q == BW'(FRAME_BITS - 1));

    // A reset request in the PUSH cycle aborts the write as well
    assign push     = (state_q == S_PUSH) && !rst_edge;
    assign pop      = sample_valid && sample_ready;
    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign do_push  = push && (!full || pop);
    assign ovf_set  = push && full && !pop;
    assign miss_set = trig && (state_q != S_IDLE);

    always_comb begin
        per_d = per_q + PW'(1);
        if (rst_edge || state_q == S_RST || !enable || trig)
            per_d = '0;
    end

    always_comb begin
        level_d = level_q + LW'(do_push) - LW'(pop);
        ovf_d   = ovf_q;
        miss_d  = miss_q;
        if (flags_clr) begin
            ovf_d  = 1'b0;
            miss_d = 1'b0;
        end
        if (ovf_set)  ovf_d  = 1'b1;
        if (miss_set) miss_d = 1'b1;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            rc_q      <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            req_q     <= 1'b0;
            ss_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            adc_rst_q <= 1'b0;
        end else begin
            req_q <= adc_reset_req;
            if (rst_edge) begin
                state_q   <= S_RST;
                rc_q      <= '0;
                div_q     <= '0;
                ss_n_q    <= 1'b1;
                sclk_q    <= 1'b0;
                mosi_q    <= 1'b0;
                adc_rst_q <= 1'b1;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (trig) begin
                            state_q <= S_SETUP;
                            div_q   <= '0;
                            ss_n_q  <= 1'b0;
                            tx_q    <= cmd_word;
                            mosi_q  <= cmd_word[FRAME_BITS-1];
                        end
                    end
                    S_SETUP: begin
                        div_q <= div_q + DW'(1);
                        if (div_end) begin
                            div_q   <= '0;
                            bit_q   <= '0;
                            state_q <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        div_q <= div_q + DW'(1);
                        if (div_end) begin
                            div_q <= '0;
                            if (!sclk_q) begin
                                sclk_q <= 1'b1;
                                rx_q   <= {rx_q[FRAME_BITS-2:0], spi_miso};
                            end else begin
                                sclk_q <= 1'b0;
                                tx_q   <= tx_q << 1;
                                mosi_q <= last_bit ? 1'b0
                                                   : tx_q[FRAME_BITS-2];
                                bit_q  <= bit_q + BW'(1);
                                if (last_bit)
                                    state_q <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        div_q <= div_q + DW'(1);
                        if (div_end) begin
                            div_q   <= '0;
                            ss_n_q  <= 1'b1;
                            state_q <= S_PUSH;
                        end
                    end
                    S_PUSH: state_q <= S_IDLE;
                    S_RST: begin
                        rc_q <= rc_q + RW'(1);
                        if (rc_q == RW'(RESET_CYCLES - 1)) begin
                            adc_rst_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            per_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            per_q   <= per_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            miss_q  <= miss_d;
            if (do_push) wr_q <= wr_q + AW'(1);
            if (pop)     rd_q <= rd_q + AW'(1);
        end
    end

    // When full, a push with pop reuses the slot the head is leaving
    always_ff @(posedge clk_clk) begin
        if (!reset_reset && do_push)
            mem_q[wr_q] <= rx_q;
    end

    assign spi_sclk     = sclk_q;
    assign spi_mosi     = mosi_q;
    assign spi_ss_n     = ss_n_q;
    assign adc_rst      = adc_rst_q;
    assign busy         = (state_q != S_IDLE);
    assign sample_data  = mem_q[rd_q];
    assign sample_valid = (level_q != '0);
    assign fifo_level   = level_q;
    assign overflow     = ovf_q;
    assign trig_miss    = miss_q;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Bench for adc_spi_sequencer: an ADC pin model plus a queue-based
// FIFO reference, exercised scenario by scenario.
module tb_adc_spi_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        req = 1'b0;
    logic [15:0] cmd = 16'h0;
    logic        sclk, mosi, ss_n, adc_rst_o;
    logic        miso = 1'b0;
    logic [15:0] data;
    logic        valid;
    logic        ready = 1'b0;
    logic [3:0]  level;
    logic        ovf, miss;
    logic        clr = 1'b0;
    logic        busy;

    logic        en2 = 1'b0;
    logic        clr2 = 1'b0;
    logic        sclk2, mosi2, ss2, adc_rst2, valid2, ovf2, miss2, busy2;
    logic [15:0] data2;
    logic [3:0]  level2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    adc_spi_sequencer u_dut (
        .clk_clk(clk), .reset_reset(rst), .enable(enable),
        .adc_reset_req(req), .cmd_word(cmd),
        .spi_sclk(sclk), .spi_mosi(mosi), .spi_ss_n(ss_n),
        .spi_miso(miso), .adc_rst(adc_rst_o),
        .sample_data(data), .sample_valid(valid),
        .sample_ready(ready), .fifo_level(level),
        .overflow(ovf), .trig_miss(miss), .flags_clr(clr),
        .busy(busy)
    );

    adc_spi_sequencer #(.SAMPLE_PERIOD(100)) u_miss (
        .clk_clk(clk), .reset_reset(rst), .enable(en2),
        .adc_reset_req(1'b0), .cmd_word(cmd),
        .spi_sclk(sclk2), .spi_mosi(mosi2), .spi_ss_n(ss2),
        .spi_miso(miso), .adc_rst(adc_rst2),
        .sample_data(data2), .sample_valid(valid2),
        .sample_ready(1'b0), .fifo_level(level2),
        .overflow(ovf2), .trig_miss(miss2), .flags_clr(clr2),
        .busy(busy2)
    );

    // ADC model: picks a word at chip-select fall, shifts it out on
    // falling SCLK, and records the MOSI bits seen on rising SCLK.
    logic [15:0] miso_word, mosi_word;
    logic [15:0] fixed_word = 16'h0;
    bit          fixed_mode = 1'b0;
    int          bits = 0;
    logic [15:0] sent_q[$];

    always @(negedge ss_n) begin
        bits = 0;
        miso_word = fixed_mode ? fixed_word : 16'($urandom);
        sent_q.push_back(miso_word);
        miso = miso_word[15];
    end

    always @(posedge sclk) begin
        mosi_word = {mosi_word[14:0], mosi};
        bits++;
    end

    always @(negedge sclk) begin
        if (bits > 0 && bits < 16) miso = miso_word[15 - bits];
    end

    // FIFO reference: a full frame ending pushes the ADC word one cycle
    // after chip select deasserts.
    logic [15:0] mq[$];
    bit          exp_ovf = 1'b0;
    logic        prev_ss = 1'b1;
    int          lowcnt = 0;
    int          frame_len = 0;
    bit          m_pop, m_push, m_full;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_ovf = 1'b0;
            lowcnt = 0;
        end else begin
            m_pop  = (mq.size() != 0) && ready;
            m_full = (mq.size() == 8);
            m_push = ss_n && !prev_ss && bits == 16 && !adc_rst_o;
            if (m_push && m_full && !m_pop) exp_ovf = 1'b1;
            else if (clr) exp_ovf = 1'b0;
            if (m_pop) void'(mq.pop_front());
            if (m_push && !(m_full && !m_pop)) mq.push_back(miso_word);
            if (!ss_n) lowcnt++;
            else if (!prev_ss) begin
                frame_len = lowcnt;
                lowcnt = 0;
            end
        end
        prev_ss = ss_n;
    end

    function automatic logic pick(input int sel);
        case (sel)
            0:       return ss_n;
            1:       return ss2;
            default: return sclk;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input bit rise,
                            input int budget, output bit ok);
        logic p, c;
        ok = 1'b0;
        p = pick(sel);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            c = pick(sel);
            if ((rise && !p && c) || (!rise && p && !c)) begin
                ok = 1'b1;
                return;
            end
            p = c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (ss_n !== 1'b1) begin tests_failed++; $display("FAIL rst_ss_n got %b want 1", ss_n); end
        tests_run++; if (sclk !== 1'b0) begin tests_failed++; $display("FAIL rst_sclk got %b want 0", sclk); end
        tests_run++; if (mosi !== 1'b0) begin tests_failed++; $display("FAIL rst_mosi got %b want 0", mosi); end
        tests_run++; if (adc_rst_o !== 1'b0) begin tests_failed++; $display("FAIL rst_adc_rst got %b want 0", adc_rst_o); end
        tests_run++; if (valid !== 1'b0 || level !== 4'd0) begin tests_failed++; $display("FAIL rst_fifo got v=%b l=%0d want 0/0", valid, level); end
        tests_run++; if (ovf !== 1'b0 || miss !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_flags got %b%b%b want 000", ovf, miss, busy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        bit ok;
        fixed_mode = 1'b1;
        fixed_word = 16'h1234;
        cmd = 16'hA5C3;
        enable = 1'b1;
        wait_sig(0, 1'b0, 1500, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL frame_start timeout got none want ss_n fall"); end
        #1;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL frame_busy got %b want 1", busy); end
        wait_sig(0, 1'b1, 400, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL frame_end timeout got none want ss_n rise"); end
        fixed_mode = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (mosi_word !== 16'hA5C3) begin tests_failed++; $display("FAIL mosi_bits got %h want a5c3", mosi_word); end
        tests_run++; if (frame_len !== 136) begin tests_failed++; $display("FAIL frame_len got %0d want 136", frame_len); end
        tests_run++; if (data !== 16'h1234 || valid !== 1'b1) begin tests_failed++; $display("FAIL frame_data got %h v=%b want 1234 v=1", data, valid); end
        tests_run++; if (level !== 4'(mq.size()) || level !== 4'd1) begin tests_failed++; $display("FAIL frame_level got %0d want 1", level); end
        tests_run++; if (ovf !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL frame_flags got ovf=%b busy=%b want 0/0", ovf, busy); end
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        tests_run++; if (level !== 4'd0 || valid !== 1'b0) begin tests_failed++; $display("FAIL frame_pop got l=%0d v=%b want 0/0", level, valid); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [15:0] exp_cmd;
        sent_q.delete();
        for (int f = 0; f < 9; f++) begin
            exp_cmd = 16'($urandom);
            cmd = exp_cmd;
            wait_sig(0, 1'b1, 1500, ok);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL ovf_frame%0d timeout got none want frame", f); end
            tests_run++; if (mosi_word !== exp_cmd) begin tests_failed++; $display("FAIL ovf_mosi%0d got %h want %h", f, mosi_word, exp_cmd); end
        end
        @(posedge clk); #1;
        tests_run++; if (level !== 4'd8 || level !== 4'(mq.size())) begin tests_failed++; $display("FAIL ovf_level got %0d want 8", level); end
        tests_run++; if (ovf !== exp_ovf || ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b want 1", ovf); end
        tests_run++; if (sent_q.size() < 9 || data !== sent_q[0]) begin tests_failed++; $display("FAIL ovf_head got %h want first word", data); end
    endtask

    task automatic test_full_pop();
        bit ok;
        logic [15:0] exp[8];
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL clr_ovf got %b want 0", ovf); end
        wait_sig(0, 1'b1, 1500, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL fullpop_frame timeout got none want frame"); end
        ready = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (level !== 4'd8) begin tests_failed++; $display("FAIL fullpop_level got %0d want 8", level); end
        tests_run++; if (ovf !== 1'b0 || ovf !== exp_ovf) begin tests_failed++; $display("FAIL fullpop_ovf got %b want 0", ovf); end
        if (sent_q.size() >= 10) begin
            for (int i = 0; i < 7; i++) exp[i] = sent_q[i + 1];
            exp[7] = sent_q[9];
        end else begin
            for (int i = 0; i < 8; i++) exp[i] = 16'hxxxx;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests_run++; if (data !== exp[i] || valid !== 1'b1) begin tests_failed++; $display("FAIL drain%0d got %h want %h", i, data, exp[i]); end
            @(posedge clk);
        end
        @(negedge clk); ready = 1'b0;
        tests_run++; if (valid !== 1'b0 || level !== 4'd0) begin tests_failed++; $display("FAIL drain_empty got v=%b l=%0d want 0/0", valid, level); end
    endtask

    task automatic test_adc_reset();
        bit ok;
        int rises, cnt, cnt2;
        logic [3:0] lvl0;
        lvl0 = level;
        wait_sig(0, 1'b0, 1500, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rst_frame timeout got none want frame"); end
        rises = 0;
        for (int i = 0; i < 7; i++) begin
            wait_sig(2, 1'b1, 20, ok);
            if (ok) rises++;
        end
        tests_run++; if (rises !== 7) begin tests_failed++; $display("FAIL rst_bits got %0d want 7", rises); end
        @(negedge clk); req = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (ss_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin tests_failed++; $display("FAIL abort_pins got %b%b%b want 100", ss_n, sclk, mosi); end
        tests_run++; if (adc_rst_o !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL abort_pulse got rst=%b busy=%b want 1/1", adc_rst_o, busy); end
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (adc_rst_o && cnt < 40);
        req = 1'b0;
        tests_run++; if (cnt !== 16) begin tests_failed++; $display("FAIL pulse_width got %0d want 16", cnt); end
        tests_run++; if (level !== lvl0 || level !== 4'(mq.size())) begin tests_failed++; $display("FAIL abort_nopush got %0d want %0d", level, lvl0); end
        cnt2 = 0;
        do begin
            @(posedge clk); #1;
            cnt2++;
        end while (ss_n && cnt2 < 3000);
        tests_run++; if (cnt2 !== 1000) begin tests_failed++; $display("FAIL restart_gap got %0d want 1000", cnt2); end
        wait_sig(0, 1'b1, 400, ok);
        @(posedge clk); #1;
        tests_run++; if (!ok || level !== lvl0 + 4'd1 || data !== sent_q[$]) begin tests_failed++; $display("FAIL post_rst_frame got l=%0d d=%h want %0d/%h", level, data, lvl0 + 4'd1, sent_q[$]); end
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
    endtask

    task automatic test_trig_miss();
        bit ok;
        @(negedge clk); en2 = 1'b1;
        wait_sig(1, 1'b0, 300, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL miss_frame timeout got none want frame"); end
        repeat (99) @(posedge clk);
        #1;
        tests_run++; if (miss2 !== 1'b0) begin tests_failed++; $display("FAIL miss_early got %b want 0", miss2); end
        @(posedge clk); #1;
        tests_run++; if (miss2 !== 1'b1) begin tests_failed++; $display("FAIL miss_set got %b want 1", miss2); end
        @(negedge clk); clr2 = 1'b1;
        @(posedge clk); #1;
        clr2 = 1'b0;
        tests_run++; if (miss2 !== 1'b0) begin tests_failed++; $display("FAIL miss_clr got %b want 0", miss2); end
        wait_sig(1, 1'b0, 300, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL miss_frame2 timeout got none want frame"); end
        repeat (99) @(posedge clk);
        @(negedge clk); clr2 = 1'b1;
        @(posedge clk); #1;
        clr2 = 1'b0;
        tests_run++; if (miss2 !== 1'b1) begin tests_failed++; $display("FAIL miss_setwins got %b want 1", miss2); end
        en2 = 1'b0;
    endtask

    task automatic test_reset_midshift();
        bit ok;
        wait_sig(0, 1'b0, 1500, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL mid_frame timeout got none want frame"); end
        repeat (40) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (ss_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || adc_rst_o !== 1'b0) begin tests_failed++; $display("FAIL mid_pins got %b%b%b%b want 1000", ss_n, sclk, mosi, adc_rst_o); end
        tests_run++; if (busy !== 1'b0 || valid !== 1'b0 || level !== 4'd0) begin tests_failed++; $display("FAIL mid_state got b=%b v=%b l=%0d want 0/0/0", busy, valid, level); end
        tests_run++; if (ovf !== 1'b0 || miss !== 1'b0 || miss2 !== 1'b0) begin tests_failed++; $display("FAIL mid_flags got %b%b%b want 000", ovf, miss, miss2); end
        @(negedge clk); rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        tests_run++; if (level !== 4'd0 || valid !== 1'b0) begin tests_failed++; $display("FAIL mid_nopush got l=%0d v=%b want 0/0", level, valid); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_full_pop();
        test_adc_reset();
        test_trig_miss();
        test_reset_midshift();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
